tcdm_g_streamer: RTL

Sequential request generator sitting directly upstream of the wide TCDM bank splitter: it issues one SIZE-lane-wide SRAM access per cycle over a strided address window and drives the splitter's single shared slave port. Loads return through a bounded FIFO as a valid/ready read stream. Stores are taken from a valid/ready write stream. The SRAM side has no grant (point-to-point, no arbitration) and fixed 1-cycle read latency.

---
 rtl/tcdm_g_streamer_pkg.sv | 11 +
 rtl/tcdm_g_streamer_if.sv | 56 +++++
 rtl/tcdm_g_streamer_fifo.sv | 61 ++++++
 rtl/tcdm_g_streamer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/tcdm_g_streamer_pkg.sv
// Shared types for the TCDM streamer: FSM state encoding.
package tcdm_g_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/tcdm_g_streamer_if.sv
// Config, read/write stream and SRAM-side bus of the streamer, bundled with
// master (streamer) and slave (environment) views.
interface tcdm_g_streamer_if #(
    parameter int unsigned ADDR_SRAM_WIDTH = 10,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned SIZE            = 1,
    parameter int unsigned LEN_WIDTH       = ADDR_SRAM_WIDTH + 1
);
    logic                         cfg_start;
    logic                         cfg_wen;
    logic [ADDR_SRAM_WIDTH-1:0]   cfg_base;
    logic [ADDR_SRAM_WIDTH-1:0]   cfg_stride;
    logic [LEN_WIDTH-1:0]         cfg_len;
    logic                         busy;
    logic                         done;

    logic                         rd_valid;
    logic                         rd_ready;
    logic [SIZE*DATA_WIDTH-1:0]   rd_data;

    logic                         wr_valid;
    logic                         wr_ready;
    logic [SIZE*DATA_WIDTH-1:0]   wr_data;
    logic [SIZE*BE_WIDTH-1:0]     wr_be;

    logic                         sram_req;
    logic [ADDR_SRAM_WIDTH-1:0]   sram_add;
    logic                         sram_wen;
    logic [SIZE*DATA_WIDTH-1:0]   sram_wdata;
    logic [SIZE*BE_WIDTH-1:0]     sram_be;
    logic [SIZE*DATA_WIDTH-1:0]   sram_rdata;

    modport master (
        input  cfg_start, cfg_wen, cfg_base, cfg_stride, cfg_len,
        output busy, done,
        output rd_valid, rd_data,
        input  rd_ready,
        input  wr_valid, wr_data, wr_be,
        output wr_ready,
        output sram_req, sram_add, sram_wen, sram_wdata, sram_be,
        input  sram_rdata
    );

    modport slave (
        output cfg_start, cfg_wen, cfg_base, cfg_stride, cfg_len,
        input  busy, done,
        input  rd_valid, rd_data,
        output rd_ready,
        output wr_valid, wr_data, wr_be,
        input  wr_ready,
        input  sram_req, sram_add, sram_wen, sram_wdata, sram_be,
        output sram_rdata
    );

endinterface

// File: rtl/tcdm_g_streamer_fifo.sv
// Synchronous FIFO with registered storage; head is presented directly and
// reads as zero while empty.
module tcdm_g_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= next_ptr(wptr_q);
            if (do_pop)  rptr_q <= next_ptr(rptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Upstream throttling guarantees space; a full push means that broke.
    assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/tcdm_g_streamer.sv
// Strided SRAM request generator: loads return through a bounded FIFO as a
// read stream, stores pass straight through from the write stream.
module tcdm_g_streamer
    import tcdm_g_pkg::*;
#(
    parameter int unsigned ADDR_SRAM_WIDTH = 10,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned SIZE            = 1,
    parameter int unsigned LEN_WIDTH       = ADDR_SRAM_WIDTH + 1,
    parameter int unsigned FIFO_DEPTH      = 3
) (
    input  logic               clk,
    input  logic               rst,
    tcdm_g_streamer_if.master  bus
);
    localparam int unsigned DW = SIZE * DATA_WIDTH;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    state_e                     state_q;
    logic [ADDR_SRAM_WIDTH-1:0] addr_q, stride_q;
    logic [LEN_WIDTH-1:0]       rem_q;
    logic                       inflight_q, done_q, busy_q;

    logic [CW:0]   outstanding;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic [DW-1:0] fifo_data;
    logic          can_issue, issue_rd, wr_acc, in_wr, last_beat;

    // Loads already in flight count against FIFO space so a stalled consumer
    // can never cause an overflow.
    assign outstanding = {1'b0, fifo_cnt} + (CW + 1)'(inflight_q);
    assign can_issue   = outstanding < (CW + 1)'(FIFO_DEPTH);
    assign in_wr       = (state_q == WR);
    assign issue_rd    = (state_q == RD) && can_issue;
    assign wr_acc      = in_wr && bus.wr_valid;
    assign last_beat   = (rem_q == LEN_WIDTH'(1));

    assign bus.sram_req   = issue_rd || wr_acc;
    assign bus.sram_add   = addr_q;
    assign bus.sram_wen   = !in_wr;
    assign bus.sram_wdata = in_wr ? bus.wr_data : '0;
    assign bus.sram_be    = in_wr ? bus.wr_be   : '0;
    assign bus.wr_ready   = in_wr;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rd_valid   = !fifo_empty;
    assign bus.rd_data    = fifo_data;

    tcdm_g_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .data_i  (bus.sram_rdata),
        .pop_i   (bus.rd_ready),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue_rd;
            case (state_q)
                IDLE: begin
                    if (bus.cfg_start) begin
                        addr_q   <= bus.cfg_base;
                        stride_q <= bus.cfg_stride;
                        rem_q    <= bus.cfg_len;
                        if (bus.cfg_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= bus.cfg_wen ? RD : WR;
                        end
                    end
                end
                RD: begin
                    if (issue_rd) begin
                        addr_q <= addr_q + stride_q;
                        rem_q  <= rem_q - LEN_WIDTH'(1);
                        if (last_beat) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !inflight_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WR: begin
                    if (wr_acc) begin
                        addr_q <= addr_q + stride_q;
                        rem_q  <= rem_q - LEN_WIDTH'(1);
                        if (last_beat) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
